// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select encodings and default register address width shared by the hazard logic
package hazard_pkg;
  localparam int DEFAULT_AW = 5;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending bit per register (set_i/set_reg_i, clr_i/clr_reg_i in; pending_o vector, busy_o any-set out), set beats clear, x0 never pending
module reg_scoreboard import hazard_pkg::*; #(
  parameter int AW = DEFAULT_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_i,
  input  logic [AW-1:0]        set_reg_i,
  input  logic                 clr_i,
  input  logic [AW-1:0]        clr_reg_i,
  output logic [(2**AW)-1:0]   pending_o,
  output logic                 busy_o
);
  logic [(2**AW)-1:0] pending_q, pending_d;
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_reg_i] = 1'b0;
    if (set_i) pending_d[set_reg_i] = 1'b1;
    pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else pending_q <= pending_d;
  end
  assign pending_o = pending_q;
  assign busy_o = |pending_q;
endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: operand forward selects, load-use/RAW/WAW decode stall, long-latency scoreboard (busy) and sticky stall watchdog (stall_timeout)
module fwd_hazard_scoreboard import hazard_pkg::*; #(
  parameter int AW = DEFAULT_AW,
  parameter int NUM_SRC = 2,
  parameter int MAX_STALL = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_mem_reg_write,
  input  logic [AW-1:0]           ex_mem_write_reg,
  input  logic                    mem_wb_reg_write,
  input  logic [AW-1:0]           mem_wb_write_reg,
  input  logic [NUM_SRC*AW-1:0]   id_ex_src,
  input  logic                    id_ex_mem_read,
  input  logic [AW-1:0]           id_ex_write_reg,
  input  logic [NUM_SRC*AW-1:0]   if_id_src,
  input  logic [NUM_SRC-1:0]      if_id_src_valid,
  input  logic [AW-1:0]           if_id_dest,
  input  logic                    if_id_dest_valid,
  input  logic                    ll_issue,
  input  logic                    ll_done,
  input  logic [AW-1:0]           ll_done_reg,
  output logic [2*NUM_SRC-1:0]    fwd_sel,
  output logic                    stall,
  output logic                    flush_id_ex,
  output logic                    busy,
  output logic                    stall_timeout
);
  localparam int CW = $clog2(MAX_STALL + 1);
  logic [(2**AW)-1:0] pending;
  logic load_use, raw, waw, sb_set, tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++)
      fwd_sel[2*i +: 2] = (ex_mem_reg_write && ex_mem_write_reg != '0 && ex_mem_write_reg == id_ex_src[i*AW +: AW]) ? FWD_EX_MEM :
                          (mem_wb_reg_write && mem_wb_write_reg != '0 && mem_wb_write_reg == id_ex_src[i*AW +: AW]) ? FWD_MEM_WB : FWD_REGFILE;
  end
  always_comb begin
    load_use = 1'b0;
    raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      load_use |= if_id_src_valid[i] && id_ex_mem_read && id_ex_write_reg != '0 && if_id_src[i*AW +: AW] == id_ex_write_reg;
      raw |= if_id_src_valid[i] && pending[if_id_src[i*AW +: AW]];
    end
    waw = if_id_dest_valid && pending[if_id_dest];
  end
  assign stall = load_use | raw | waw;
  assign flush_id_ex = stall;
  assign sb_set = ll_issue && !stall && if_id_dest_valid && if_id_dest != '0;
  reg_scoreboard #(.AW(AW)) u_sb (
    .clk(clk),
    .reset(reset),
    .set_i(sb_set),
    .set_reg_i(if_id_dest),
    .clr_i(ll_done),
    .clr_reg_i(ll_done_reg),
    .pending_o(pending),
    .busy_o(busy)
  );
  assign cnt_d = !stall ? '0 : (cnt_q == CW'(MAX_STALL)) ? cnt_q : cnt_q + 1'b1;
  assign tmo_d = tmo_q | (cnt_d == CW'(MAX_STALL));
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign stall_timeout = tmo_q;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed plus random stimulus scored against a queue-fed reference model
module tb_fwd_hazard_scoreboard;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int MS = 4;
  typedef struct packed {
    logic rst, exw;
    logic [AW-1:0] exr;
    logic wbw;
    logic [AW-1:0] wbr;
    logic [NS*AW-1:0] exs;
    logic mr;
    logic [AW-1:0] idw;
    logic [NS*AW-1:0] ifs;
    logic [NS-1:0] sv;
    logic [AW-1:0] dst;
    logic dv, iss, dn;
    logic [AW-1:0] dnr;
  } stim_t;
  typedef struct packed {
    logic [2*NS-1:0] fwd;
    logic stl, bsy, tmo;
  } exp_t;
  logic clk = 1'b0;
  stim_t cur;
  logic [2*NS-1:0] fwd_sel;
  logic stall, flush_id_ex, busy, stall_timeout;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  bit pend[1<<AW];
  int run = 0;
  bit tmo = 0;
  always #5 clk = ~clk;
  fwd_hazard_scoreboard #(.AW(AW), .NUM_SRC(NS), .MAX_STALL(MS)) dut (
    .clk(clk),
    .reset(cur.rst),
    .ex_mem_reg_write(cur.exw),
    .ex_mem_write_reg(cur.exr),
    .mem_wb_reg_write(cur.wbw),
    .mem_wb_write_reg(cur.wbr),
    .id_ex_src(cur.exs),
    .id_ex_mem_read(cur.mr),
    .id_ex_write_reg(cur.idw),
    .if_id_src(cur.ifs),
    .if_id_src_valid(cur.sv),
    .if_id_dest(cur.dst),
    .if_id_dest_valid(cur.dv),
    .ll_issue(cur.iss),
    .ll_done(cur.dn),
    .ll_done_reg(cur.dnr),
    .fwd_sel(fwd_sel),
    .stall(stall),
    .flush_id_ex(flush_id_ex),
    .busy(busy),
    .stall_timeout(stall_timeout)
  );
  function automatic logic m_stall(stim_t s);
    logic h;
    logic [AW-1:0] r;
    h = 1'b0;
    for (int i = 0; i < NS; i++) begin
      r = s.ifs[i*AW +: AW];
      if (s.sv[i] && s.mr && s.idw != 0 && r == s.idw) h = 1'b1;
      if (s.sv[i] && pend[r]) h = 1'b1;
    end
    if (s.dv && pend[s.dst]) h = 1'b1;
    return h;
  endfunction
  function automatic exp_t m_out(stim_t s);
    exp_t x;
    logic [AW-1:0] r;
    x = '0;
    for (int i = 0; i < NS; i++) begin
      r = s.exs[i*AW +: AW];
      x.fwd[2*i +: 2] = (s.exw && s.exr != 0 && s.exr == r) ? 2'b10 :
                        (s.wbw && s.wbr != 0 && s.wbr == r) ? 2'b01 : 2'b00;
    end
    x.stl = m_stall(s);
    for (int k = 0; k < (1<<AW); k++) if (pend[k]) x.bsy = 1'b1;
    x.tmo = tmo;
    return x;
  endfunction
  task automatic commit();
    logic st;
    if (cur.rst) begin
      for (int k = 0; k < (1<<AW); k++) pend[k] = 0;
      run = 0;
      tmo = 0;
    end else begin
      st = m_stall(cur);
      run = st ? run + 1 : 0;
      if (run >= MS) tmo = 1;
      if (cur.dn) pend[cur.dnr] = 0;
      if (cur.iss && !st && cur.dv && cur.dst != 0) pend[cur.dst] = 1;
    end
  endtask
  task automatic step(input stim_t s);
    @(posedge clk);
    commit();
    #1;
    cur = s;
    q.push_back(m_out(s));
  endtask
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwd_sel", 8'(fwd_sel), 8'(e.fwd));
      chk("stall", 8'(stall), 8'(e.stl));
      chk("flush_id_ex", 8'(flush_id_ex), 8'(e.stl));
      chk("busy", 8'(busy), 8'(e.bsy));
      chk("stall_timeout", 8'(stall_timeout), 8'(e.tmo));
    end
  end
  initial begin
    stim_t s;
    cur = '0;
    cur.rst = 1'b1;
    s = '0; s.rst = 1'b1;
    step(s); step(s);
    s = '0; s.exw = 1; s.exr = 5; s.wbw = 1; s.wbr = 5; s.exs = {5'd0, 5'd5};
    step(s);
    s.exw = 0; step(s);
    s.exw = 1; s.exr = 0; s.wbr = 0; step(s);
    s.exr = 5; s.wbr = 3; s.exs = {5'd3, 5'd5}; step(s);
    s = '0; s.mr = 1; s.idw = 7; s.ifs = {5'd7, 5'd0}; s.sv = 2'b10;
    step(s);
    s.sv = 2'b01; step(s);
    s = '0; s.iss = 1; s.dv = 1; s.dst = 9; step(s);
    s = '0; s.ifs = {5'd0, 5'd9}; s.sv = 2'b01;
    step(s); step(s);
    s.dn = 1; s.dnr = 9; step(s);
    s.dn = 0; step(s);
    s = '0; s.iss = 1; s.dv = 1; s.dst = 9; step(s);
    s.iss = 0; step(s);
    s = '0; s.dn = 1; s.dnr = 9; step(s);
    s = '0; s.iss = 1; s.dv = 1; s.dst = 3; s.dn = 1; s.dnr = 3; step(s);
    s = '0; s.ifs = {5'd0, 5'd3}; s.sv = 2'b01; step(s);
    s = '0; s.dn = 1; s.dnr = 3; step(s);
    s = '0; s.dn = 1; s.dnr = 12; step(s);
    s = '0; s.iss = 1; s.dv = 1; s.dst = 6; step(s);
    s = '0; s.ifs = {5'd6, 5'd0}; s.sv = 2'b10;
    for (int i = 0; i < 6; i++) step(s);
    s = '0; s.dn = 1; s.dnr = 6; step(s);
    s = '0; step(s); step(s);
    s.rst = 1; step(s);
    s = '0; step(s);
    s = '0; s.iss = 1; s.dv = 1; s.dst = 4; step(s);
    s = '0; step(s);
    s.rst = 1; step(s);
    s = '0; s.dn = 1; s.dnr = 4; step(s);
    s = '0; s.ifs = {5'd0, 5'd4}; s.sv = 2'b01; s.dst = 4; s.dv = 1; step(s);
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.rst = ($urandom_range(0, 79) == 0);
      s.exw = 1'($urandom);
      s.exr = AW'($urandom_range(0, 15));
      s.wbw = 1'($urandom);
      s.wbr = AW'($urandom_range(0, 15));
      s.exs = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
      s.mr = ($urandom_range(0, 2) == 0);
      s.idw = AW'($urandom_range(0, 15));
      s.ifs = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
      s.sv = NS'($urandom);
      s.dst = AW'($urandom_range(0, 15));
      s.dv = 1'($urandom);
      s.iss = ($urandom_range(0, 2) == 0);
      s.dn = ($urandom_range(0, 2) == 0);
      s.dnr = AW'($urandom_range(0, 15));
      step(s);
    end
    @(negedge clk);
    #1;
    chk("queue_drain", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
